// File: rtl/por_pkg.sv
// Shared types and defaults for the power-on reset sequencer.
// State encoding is fixed because it is exported on the debug state port.
package por_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HOLD     = 2'd2,
      RUN      = 2'd3
   } por_state_t;

   localparam int POR_SYNC_STAGES   = 2;
   localparam int POR_STABLE_CYCLES = 16;
   localparam int POR_HOLD_CYCLES   = 8;

   // Phase counter width: enough for the larger of the two terminal counts, at least 1 bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Clears to 0 on reset so a downstream consumer sees "not asserted" first.
module bit_synchronizer #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
      end
   end

   assign q = sync[STAGES-1];

endmodule

// File: rtl/por_sequencer.sv
// Power-on reset sequencer: debounces a synchronized power-good, holds reset for a
// fixed interval, then releases a registered systemReset; drops from RUN count as brownouts.
module por_sequencer
   import por_pkg::*;
#(
   parameter int SYNC_STAGES   = POR_SYNC_STAGES,
   parameter int STABLE_CYCLES = POR_STABLE_CYCLES,
   parameter int HOLD_CYCLES   = POR_HOLD_CYCLES,
   parameter int CNT_W         = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             powerGood,
   output logic             systemReset,
   output logic             resetDone,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] brownoutCount
);

   localparam int CW = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

   por_state_t    st;
   logic [CW-1:0] cnt;
   logic          pgSync;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   bit_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_pg_sync (
      .clock (clock),
      .reset (reset),
      .d     (powerGood),
      .q     (pgSync)
   );

   // Outputs are driven from the state being entered, so they change on the same edge as st.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         st            <= IDLE;
         cnt           <= '0;
         systemReset   <= 1'b1;
         resetDone     <= 1'b0;
         brownoutCount <= '0;
      end else begin
         systemReset <= 1'b1;
         resetDone   <= 1'b0;
         case (st)
            IDLE: begin
               if (pgSync) begin
                  st  <= DEBOUNCE;
                  cnt <= '0;
               end
            end
            DEBOUNCE: begin
               if (!pgSync) begin
                  st  <= IDLE;
                  cnt <= '0;
               end else if (cnt == STABLE_LAST) begin
                  st  <= HOLD;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HOLD: begin
               if (!pgSync) begin
                  st  <= IDLE;
                  cnt <= '0;
               end else if (cnt == HOLD_LAST) begin
                  st          <= RUN;
                  cnt         <= '0;
                  systemReset <= 1'b0;
                  resetDone   <= 1'b1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RUN: begin
               if (!pgSync) begin
                  st            <= IDLE;
                  cnt           <= '0;
                  brownoutCount <= sat_inc(brownoutCount);
               end else begin
                  systemReset <= 1'b0;
                  resetDone   <= 1'b1;
               end
            end
            default: begin
               st  <= IDLE;
               cnt <= '0;
            end
         endcase
      end
   end

   assign state = st;

endmodule
